dda_stepper: RTL and testbench

DDA_STEPPER -- requirements
Module: dda_stepper

---
 rtl/raycast_pkg.sv | 27 ++
 rtl/dda_stepper.sv | 177 +++++++++++++++++
 tb/tb_dda_stepper.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/raycast_pkg.sv
// Shared raycaster definitions: stepper state encoding, Q8.8 constants and
// saturating distance helpers.
package raycast_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP  = 3'd1,
    FETCH = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [15:0] ONE          = 16'h0100;
  localparam logic [15:0] DIST_MAX     = 16'hFFFF;
  localparam int          MAP_SIZE_DEF = 24;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? DIST_MAX : s[15:0];
  endfunction

  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? (a - b) : 16'h0000;
  endfunction

endpackage

// File: rtl/dda_stepper.sv
// Grid DDA ray stepper: walks one ray through the tile map, one cell per four
// cycles, and reports the perpendicular distance and type of the first wall.
//
// state | meaning
// IDLE  | waiting for a ray, ray_ready_out high
// STEP  | advance one cell along the shorter side distance, issue map address
// FETCH | two cycles of map read latency
// CHECK | inspect map data: hit, timeout, or step again
// DONE  | result held on outputs until hit_ready_in
module dda_stepper
  import raycast_pkg::*;
#(
  parameter int MAP_SIZE  = MAP_SIZE_DEF,
  parameter int MAX_STEPS = 64
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        ray_valid_in,
  output logic        ray_ready_out,
  input  logic [8:0]  hcount_in,
  input  logic [15:0] posX_in,
  input  logic [15:0] posY_in,
  input  logic        stepX_in,
  input  logic        stepY_in,
  input  logic [15:0] sideDistX_in,
  input  logic [15:0] sideDistY_in,
  input  logic [15:0] deltaDistX_in,
  input  logic [15:0] deltaDistY_in,
  output logic [9:0]  map_addr_out,
  input  logic [3:0]  map_data_in,
  output logic        hit_valid_out,
  input  logic        hit_ready_in,
  output logic [15:0] wall_dist_out,
  output logic        side_out,
  output logic [3:0]  wall_type_out,
  output logic [8:0]  hcount_out
);

  localparam int                 CNT_W      = $clog2(MAX_STEPS + 1);
  localparam logic signed [7:0]  MAP_LIM    = 8'(MAP_SIZE);
  localparam logic [9:0]         MAP_SIZE_W = 10'(MAP_SIZE);

  state_t state, state_nxt;

  logic             step_x, step_y;
  logic [15:0]      sd_x, sd_y, dd_x, dd_y;
  logic [7:0]       map_x, map_y;
  logic [CNT_W-1:0] step_cnt;
  logic             fetch_cnt;

  logic             take_x;
  logic [15:0]      sd_x_new, sd_y_new;
  logic [7:0]       map_x_new, map_y_new;
  logic             oob;
  logic [9:0]       addr_nxt;
  logic [15:0]      hit_dist, oob_dist;
  logic [CNT_W-1:0] step_cnt_inc;
  logic             timeout;
  logic             accept;
  logic             unused_bits;

  // Fractional position bits only matter to the upstream side-distance setup.
  assign unused_bits = ^{posX_in[15], posX_in[7:0], posY_in[15], posY_in[7:0]};

  assign ray_ready_out = (state == IDLE) && rst_n_in;
  assign hit_valid_out = (state == DONE);
  assign accept        = (state == IDLE) && ray_valid_in;

  always_comb begin
    take_x    = (sd_x < sd_y);
    sd_x_new  = sat_add(sd_x, dd_x);
    sd_y_new  = sat_add(sd_y, dd_y);
    map_x_new = map_x;
    map_y_new = map_y;
    if (take_x) map_x_new = step_x ? map_x + 8'd1 : map_x - 8'd1;
    else        map_y_new = step_y ? map_y + 8'd1 : map_y - 8'd1;
    // Map coordinates are signed so a step left of column 0 reads as negative.
    oob = map_x_new[7] || ($signed(map_x_new) >= MAP_LIM) ||
          map_y_new[7] || ($signed(map_y_new) >= MAP_LIM);
    addr_nxt     = 10'(map_y_new[6:0]) * MAP_SIZE_W + 10'(map_x_new[6:0]);
    hit_dist     = side_out ? sat_sub(sd_y, dd_y) : sat_sub(sd_x, dd_x);
    oob_dist     = take_x ? sat_sub(sd_x_new, dd_x) : sat_sub(sd_y_new, dd_y);
    step_cnt_inc = step_cnt + 1'b1;
    timeout      = (step_cnt_inc == CNT_W'(MAX_STEPS));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ray_valid_in) state_nxt = STEP;
      STEP:    state_nxt = oob ? DONE : FETCH;
      FETCH:   if (fetch_cnt) state_nxt = CHECK;
      CHECK:   begin
        if (map_data_in != 4'd0 || timeout) state_nxt = DONE;
        else                                state_nxt = STEP;
      end
      DONE:    if (hit_ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      step_x        <= 1'b0;
      step_y        <= 1'b0;
      sd_x          <= '0;
      sd_y          <= '0;
      dd_x          <= '0;
      dd_y          <= '0;
      map_x         <= '0;
      map_y         <= '0;
      step_cnt      <= '0;
      fetch_cnt     <= 1'b0;
      map_addr_out  <= '0;
      wall_dist_out <= '0;
      side_out      <= 1'b0;
      wall_type_out <= '0;
      hcount_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            step_x     <= stepX_in;
            step_y     <= stepY_in;
            sd_x       <= sideDistX_in;
            sd_y       <= sideDistY_in;
            dd_x       <= deltaDistX_in;
            dd_y       <= deltaDistY_in;
            map_x      <= {1'b0, posX_in[14:8]};
            map_y      <= {1'b0, posY_in[14:8]};
            hcount_out <= hcount_in;
            step_cnt   <= '0;
            fetch_cnt  <= 1'b0;
          end
        end
        STEP: begin
          map_x     <= map_x_new;
          map_y     <= map_y_new;
          fetch_cnt <= 1'b0;
          if (take_x) begin
            sd_x     <= sd_x_new;
            side_out <= 1'b0;
          end else begin
            sd_y     <= sd_y_new;
            side_out <= 1'b1;
          end
          if (oob) begin
            wall_type_out <= 4'd1;
            wall_dist_out <= oob_dist;
          end else begin
            map_addr_out <= addr_nxt;
          end
        end
        FETCH: fetch_cnt <= ~fetch_cnt;
        CHECK: begin
          if (map_data_in != 4'd0) begin
            wall_type_out <= map_data_in;
            wall_dist_out <= hit_dist;
          end else begin
            step_cnt <= step_cnt_inc;
            if (timeout) begin
              wall_type_out <= 4'd0;
              wall_dist_out <= DIST_MAX;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dda_stepper.sv
// Directed bench for dda_stepper with a two-cycle-latency map model.
module tb_dda_stepper;
  import raycast_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ray_valid, ray_ready;
  logic [8:0]  hcount;
  logic [15:0] pos_x, pos_y;
  logic        step_x, step_y;
  logic [15:0] sd_x, sd_y, dd_x, dd_y;
  logic [9:0]  map_addr;
  logic [3:0]  map_data;
  logic        hit_valid, hit_ready;
  logic [15:0] wall_dist;
  logic        side;
  logic [3:0]  wall_type;
  logic [8:0]  hcount_res;

  logic [3:0]  mem [0:1023];
  logic [3:0]  map_d1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dda_stepper #(.MAP_SIZE(24), .MAX_STEPS(4)) dut (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .ray_valid_in (ray_valid),
    .ray_ready_out(ray_ready),
    .hcount_in    (hcount),
    .posX_in      (pos_x),
    .posY_in      (pos_y),
    .stepX_in     (step_x),
    .stepY_in     (step_y),
    .sideDistX_in (sd_x),
    .sideDistY_in (sd_y),
    .deltaDistX_in(dd_x),
    .deltaDistY_in(dd_y),
    .map_addr_out (map_addr),
    .map_data_in  (map_data),
    .hit_valid_out(hit_valid),
    .hit_ready_in (hit_ready),
    .wall_dist_out(wall_dist),
    .side_out     (side),
    .wall_type_out(wall_type),
    .hcount_out   (hcount_res)
  );

  always @(posedge clk) begin
    map_d1   <= mem[map_addr];
    map_data <= map_d1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_map();
    for (int i = 0; i < 1024; i++) mem[i] = 4'd0;
  endtask

  task automatic run_ray(input logic [8:0] hc, input logic [15:0] px, input logic [15:0] py,
                         input logic sx, input logic sy, input logic [15:0] sdx,
                         input logic [15:0] sdy, input logic [15:0] ddx,
                         input logic [15:0] ddy, output int lat);
    hcount = hc; pos_x = px; pos_y = py; step_x = sx; step_y = sy;
    sd_x = sdx; sd_y = sdy; dd_x = ddx; dd_y = ddy;
    ray_valid = 1'b1;
    tick();
    ray_valid = 1'b0;
    lat = -1;
    for (int c = 0; c < 100; c++) begin
      if (hit_valid) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic release_result();
    hit_ready = 1'b1;
    tick();
    hit_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ray_ready, hit_valid, wall_dist, side, wall_type, hcount_res, map_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b dist=%h side=%b type=%h hc=%h addr=%h required all 0",
               ray_ready, hit_valid, wall_dist, side, wall_type, hcount_res, map_addr);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (ray_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b required 1", ray_ready);
    end
    checks++;
    if (hit_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hit_valid: got %b required 0", hit_valid);
    end
  endtask

  task automatic test_out_of_bounds();
    int lat;
    clear_map();
    run_ray(9'd11, 16'h0080, 16'h0080, 1'b0, 1'b0, 16'h0080, 16'hFFFF, ONE, ONE, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL oob_latency: got %0d required 1", lat); end
    checks++;
    if (wall_type !== 4'd1) begin errors++; $display("FAIL oob_type: got %h required 1", wall_type); end
    checks++;
    if (wall_dist !== 16'h0080) begin errors++; $display("FAIL oob_dist: got %h required 0080", wall_dist); end
    checks++;
    if (side !== 1'b0) begin errors++; $display("FAIL oob_side: got %b required 0", side); end
    checks++;
    if (map_addr !== 10'd0) begin errors++; $display("FAIL oob_no_fetch: got addr %0d required 0", map_addr); end
    checks++;
    if (hcount_res !== 9'd11) begin errors++; $display("FAIL oob_hcount: got %0d required 11", hcount_res); end
    release_result();
  endtask

  task automatic test_x_hit();
    int lat;
    clear_map();
    mem[2*24+5] = 4'd3;
    run_ray(9'd100, 16'h0280, 16'h0280, 1'b1, 1'b1, 16'h0080, 16'h7FFF, ONE, 16'h7FFF, lat);
    checks++;
    if (lat !== 12) begin errors++; $display("FAIL xhit_latency: got %0d required 12", lat); end
    checks++;
    if (wall_dist !== 16'h0280) begin errors++; $display("FAIL xhit_dist: got %h required 0280", wall_dist); end
    checks++;
    if (side !== 1'b0) begin errors++; $display("FAIL xhit_side: got %b required 0", side); end
    checks++;
    if (wall_type !== 4'd3) begin errors++; $display("FAIL xhit_type: got %h required 3", wall_type); end
    checks++;
    if (map_addr !== 10'd53) begin errors++; $display("FAIL xhit_addr: got %0d required 53", map_addr); end
    checks++;
    if (hcount_res !== 9'd100) begin errors++; $display("FAIL xhit_hcount: got %0d required 100", hcount_res); end
    release_result();
  endtask

  task automatic test_tie_y();
    int lat;
    clear_map();
    mem[9*24+10] = 4'd5;
    run_ray(9'd200, 16'h0A80, 16'h0A80, 1'b1, 1'b0, ONE, ONE, ONE, ONE, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL tie_latency: got %0d required 4", lat); end
    checks++;
    if (side !== 1'b1) begin errors++; $display("FAIL tie_side: got %b required 1", side); end
    checks++;
    if (wall_dist !== 16'h0100) begin errors++; $display("FAIL tie_dist: got %h required 0100", wall_dist); end
    checks++;
    if (wall_type !== 4'd5) begin errors++; $display("FAIL tie_type: got %h required 5", wall_type); end
    checks++;
    if (map_addr !== 10'd226) begin errors++; $display("FAIL tie_addr: got %0d required 226", map_addr); end
    release_result();
  endtask

  task automatic test_timeout();
    int lat;
    clear_map();
    run_ray(9'd5, 16'h0280, 16'h0280, 1'b1, 1'b1, 16'h0080, 16'h7FFF, ONE, 16'h7FFF, lat);
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL timeout_latency: got %0d required 16", lat); end
    checks++;
    if (wall_type !== 4'd0) begin errors++; $display("FAIL timeout_type: got %h required 0", wall_type); end
    checks++;
    if (wall_dist !== 16'hFFFF) begin errors++; $display("FAIL timeout_dist: got %h required FFFF", wall_dist); end
    checks++;
    if (map_addr !== 10'd54) begin errors++; $display("FAIL timeout_addr: got %0d required 54", map_addr); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    clear_map();
    mem[2*24+5]  = 4'd3;
    mem[9*24+10] = 4'd5;
    run_ray(9'd7, 16'h0280, 16'h0280, 1'b1, 1'b1, 16'h0080, 16'h7FFF, ONE, 16'h7FFF, lat);
    checks++;
    if (lat !== 12) begin errors++; $display("FAIL bp_latency: got %0d required 12", lat); end
    // Next ray is offered while the result is stalled; it must be ignored.
    hcount = 9'd9; pos_x = 16'h0A80; pos_y = 16'h0A80; step_x = 1'b1; step_y = 1'b0;
    sd_x = ONE; sd_y = ONE; dd_x = ONE; dd_y = ONE;
    ray_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (hit_valid !== 1'b1 || ray_ready !== 1'b0 || wall_dist !== 16'h0280 ||
          side !== 1'b0 || wall_type !== 4'd3 || hcount_res !== 9'd7) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b dist=%h side=%b type=%h hc=%0d required 1 0 0280 0 3 7",
                 c, hit_valid, ray_ready, wall_dist, side, wall_type, hcount_res);
      end
    end
    hit_ready = 1'b1;
    tick();
    hit_ready = 1'b0;
    checks++;
    if (hit_valid !== 1'b0 || ray_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b required 0 1", hit_valid, ray_ready);
    end
    run_ray(9'd9, 16'h0A80, 16'h0A80, 1'b1, 1'b0, ONE, ONE, ONE, ONE, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL b2b_latency: got %0d required 4", lat); end
    checks++;
    if (side !== 1'b1 || wall_dist !== 16'h0100 || wall_type !== 4'd5 || hcount_res !== 9'd9) begin
      errors++;
      $display("FAIL b2b_result: got side=%b dist=%h type=%h hc=%0d required 1 0100 5 9",
               side, wall_dist, wall_type, hcount_res);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_map();
    mem[2*24+5] = 4'd3;
    hcount = 9'd42; pos_x = 16'h0280; pos_y = 16'h0280; step_x = 1'b1; step_y = 1'b1;
    sd_x = 16'h0080; sd_y = 16'h7FFF; dd_x = ONE; dd_y = 16'h7FFF;
    ray_valid = 1'b1;
    tick();
    ray_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ray_ready, hit_valid, wall_dist, side, wall_type, hcount_res, map_addr} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%b vld=%b dist=%h side=%b type=%h hc=%h addr=%h required all 0",
               ray_ready, hit_valid, wall_dist, side, wall_type, hcount_res, map_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (ray_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b required 1", ray_ready); end
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (hit_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset_stale: hit_valid seen 1 required 0"); end
  endtask

  initial begin
    rst_n = 1'b1; ray_valid = 1'b0; hit_ready = 1'b0;
    hcount = '0; pos_x = '0; pos_y = '0; step_x = 1'b0; step_y = 1'b0;
    sd_x = '0; sd_y = '0; dd_x = '0; dd_y = '0;
    clear_map();
    test_reset();
    test_out_of_bounds();
    test_x_hit();
    test_tie_y();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
